// File: rtl/softmax_batch_sched_pkg.sv
// ============================================================================
// Module : softmax_pkg
// Brief  : Shared state encoding and softmax_core default geometry.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package softmax_pkg;

    localparam int unsigned c_AW        = 10;
    localparam int unsigned c_DW        = 32;
    localparam int unsigned c_DATA_SIZE = 128;

    typedef logic [2:0] state_t;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LAUNCH = 3'd1;
    localparam logic [2:0] c_ST_RUN    = 3'd2;
    localparam logic [2:0] c_ST_NEXT   = 3'd3;
    localparam logic [2:0] c_ST_FINISH = 3'd4;

endpackage

`default_nettype wire

// File: rtl/softmax_batch_sched_addr_reloc.sv
// ============================================================================
// Module : softmax_addr_reloc
// Brief  : Combinational base+offset relocation of core addresses and write gate.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module softmax_addr_reloc
    import softmax_pkg::*;
#(
    parameter int AW  = c_AW,
    parameter int GAW = 16,
    parameter int DW  = c_DW
)(
    input  logic [GAW-1:0] i_src_ptr,
    input  logic [GAW-1:0] i_dst_ptr,
    input  logic [AW-1:0]  i_rd_off,
    input  logic [AW-1:0]  i_wr_off,
    input  logic           i_wr_ena,
    input  logic           i_run,
    input  logic [DW-1:0]  i_wr_data,
    output logic [GAW-1:0] o_rd_addr,
    output logic [GAW-1:0] o_wr_addr,
    output logic           o_wr_ena,
    output logic [DW-1:0]  o_wr_data
);

    logic [GAW-1:0] w_rd_off;
    logic [GAW-1:0] w_wr_off;

    assign w_rd_off = GAW'(i_rd_off);
    assign w_wr_off = GAW'(i_wr_off);

    // Sums wrap silently mod 2^GAW; no pipeline stage so core read timing is kept.
    assign o_rd_addr = i_src_ptr + w_rd_off;
    assign o_wr_addr = i_dst_ptr + w_wr_off;
    assign o_wr_ena  = i_wr_ena & i_run;
    assign o_wr_data = i_wr_data;

endmodule

`default_nettype wire

// File: rtl/softmax_batch_sched.sv
// ============================================================================
// Module : softmax_batch_sched
// Brief  : Runs softmax_core over a batch of vectors, relocating its addresses.
//          Optional cycle counter enabled by macro SOFTMAX_SCHED_PERF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module softmax_batch_sched
    import softmax_pkg::*;
#(
    parameter int AW        = c_AW,
    parameter int GAW       = 16,
    parameter int DW        = c_DW,
    parameter int CW        = 8,
    parameter int DATA_SIZE = c_DATA_SIZE
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           batch_start,
    input  logic [CW-1:0]  num_vec,
    input  logic [GAW-1:0] src_base,
    input  logic [GAW-1:0] dst_base,
    output logic           batch_busy,
    output logic           batch_done,
    output logic [CW-1:0]  vec_idx,
`ifdef SOFTMAX_SCHED_PERF_EN
    output logic [31:0]    perf_cycles,
`endif
    output logic           core_start,
    input  logic           core_done,
    input  logic [AW-1:0]  core_rd_addr,
    input  logic           core_wr_ena,
    input  logic [AW-1:0]  core_wr_addr,
    input  logic [DW-1:0]  core_wr_data,
    output logic [GAW-1:0] mem_rd_addr,
    output logic           mem_wr_ena,
    output logic [GAW-1:0] mem_wr_addr,
    output logic [DW-1:0]  mem_wr_data
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_num_vec;
    logic [CW-1:0]  r_vec_idx;
    logic [GAW-1:0] r_src_ptr;
    logic [GAW-1:0] r_dst_ptr;
    logic           r_busy;
    logic           r_done;
    logic           r_core_start;
    logic           w_accept;
    logic           w_last_vec;

    assign w_accept   = (r_state == c_ST_IDLE) && batch_start;
    assign w_last_vec = (r_vec_idx == (r_num_vec - CW'(1)));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (batch_start) begin
                    w_state_nxt = (num_vec != '0) ? c_ST_LAUNCH : c_ST_FINISH;
                end
            end
            c_ST_LAUNCH: w_state_nxt = c_ST_RUN;
            c_ST_RUN: begin
                if (core_done) begin
                    w_state_nxt = c_ST_NEXT;
                end
            end
            c_ST_NEXT:   w_state_nxt = w_last_vec ? c_ST_FINISH : c_ST_LAUNCH;
            c_ST_FINISH: w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Status strobes are registered off the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_core_start <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= (w_state_nxt == c_ST_LAUNCH) ||
                            (w_state_nxt == c_ST_RUN)    ||
                            (w_state_nxt == c_ST_NEXT);
            r_done       <= (w_state_nxt == c_ST_FINISH);
            r_core_start <= (w_state_nxt == c_ST_LAUNCH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num_vec <= '0;
            r_vec_idx <= '0;
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
        end else if (w_accept && (num_vec != '0)) begin
            r_num_vec <= num_vec;
            r_vec_idx <= '0;
            r_src_ptr <= src_base;
            r_dst_ptr <= dst_base;
        end else if ((r_state == c_ST_NEXT) && !w_last_vec) begin
            r_vec_idx <= r_vec_idx + CW'(1);
            r_src_ptr <= r_src_ptr + GAW'(DATA_SIZE);
            r_dst_ptr <= r_dst_ptr + GAW'(DATA_SIZE);
        end
    end

`ifdef SOFTMAX_SCHED_PERF_EN
    logic [31:0] r_perf_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_cycles <= '0;
        end else if (w_accept) begin
            r_perf_cycles <= '0;
        end else if (r_busy && (r_perf_cycles != 32'hFFFF_FFFF)) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
`endif

    assign batch_busy = r_busy;
    assign batch_done = r_done;
    assign core_start = r_core_start;
    assign vec_idx    = r_vec_idx;

    softmax_addr_reloc #(
        .AW  (AW),
        .GAW (GAW),
        .DW  (DW)
    ) u_reloc (
        .i_src_ptr (r_src_ptr),
        .i_dst_ptr (r_dst_ptr),
        .i_rd_off  (core_rd_addr),
        .i_wr_off  (core_wr_addr),
        .i_wr_ena  (core_wr_ena),
        .i_run     (r_state == c_ST_RUN),
        .i_wr_data (core_wr_data),
        .o_rd_addr (mem_rd_addr),
        .o_wr_addr (mem_wr_addr),
        .o_wr_ena  (mem_wr_ena),
        .o_wr_data (mem_wr_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_softmax_batch_sched.sv
// ============================================================================
// Module : tb_softmax_batch_sched
// Brief  : Self-checking bench for softmax_batch_sched with a delayed-done core model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_softmax_batch_sched;

    localparam int AW        = 10;
    localparam int GAW       = 16;
    localparam int DW        = 32;
    localparam int CW        = 8;
    localparam int DATA_SIZE = 128;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           batch_start = 1'b0;
    logic [CW-1:0]  num_vec = '0;
    logic [GAW-1:0] src_base = '0;
    logic [GAW-1:0] dst_base = '0;
    logic           batch_busy;
    logic           batch_done;
    logic [CW-1:0]  vec_idx;
    logic           core_start;
    logic           core_done;
    logic [AW-1:0]  core_rd_addr = '0;
    logic           core_wr_ena = 1'b0;
    logic [AW-1:0]  core_wr_addr = '0;
    logic [DW-1:0]  core_wr_data = '0;
    logic [GAW-1:0] mem_rd_addr;
    logic           mem_wr_ena;
    logic [GAW-1:0] mem_wr_addr;
    logic [DW-1:0]  mem_wr_data;
`ifdef SOFTMAX_SCHED_PERF_EN
    logic [31:0]    perf_cycles;
`endif

    int errors = 0;
    int checks = 0;
    int core_lat = 40;
    int r_cnt;

    always #5 clk = ~clk;

    softmax_batch_sched #(
        .AW(AW), .GAW(GAW), .DW(DW), .CW(CW), .DATA_SIZE(DATA_SIZE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .batch_start  (batch_start),
        .num_vec      (num_vec),
        .src_base     (src_base),
        .dst_base     (dst_base),
        .batch_busy   (batch_busy),
        .batch_done   (batch_done),
        .vec_idx      (vec_idx),
`ifdef SOFTMAX_SCHED_PERF_EN
        .perf_cycles  (perf_cycles),
`endif
        .core_start   (core_start),
        .core_done    (core_done),
        .core_rd_addr (core_rd_addr),
        .core_wr_ena  (core_wr_ena),
        .core_wr_addr (core_wr_addr),
        .core_wr_data (core_wr_data),
        .mem_rd_addr  (mem_rd_addr),
        .mem_wr_ena   (mem_wr_ena),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data)
    );

    // Core model: core_done pulses core_lat cycles after the core_start cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 0;
            core_done <= 1'b0;
        end else if (core_start) begin
            if (core_lat <= 1) begin
                core_done <= 1'b1;
                r_cnt     <= 0;
            end else begin
                core_done <= 1'b0;
                r_cnt     <= core_lat - 1;
            end
        end else if (r_cnt == 1) begin
            core_done <= 1'b1;
            r_cnt     <= 0;
        end else begin
            core_done <= 1'b0;
            if (r_cnt > 0) r_cnt <= r_cnt - 1;
        end
    end

    typedef struct {
        int             nv;
        logic [GAW-1:0] src;
        logic [GAW-1:0] dst;
        logic [AW-1:0]  rd;
        logic [AW-1:0]  wr;
        int             lat;
        bit             inject;
        logic [GAW-1:0] exp_rd_last;
        logic [GAW-1:0] exp_wr_last;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [GAW-1:0] ref_addr(input logic [GAW-1:0] base, input int idx,
                                                input logic [AW-1:0] off);
        return GAW'(int'(base) + idx * DATA_SIZE + int'(off));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_batch(input vec_t v);
        int          starts = 0;
        int          busy = 0;
        int          t_cd = -1;
        int          budget;
        bit          in_run = 1'b0;
        bit          got_done = 1'b0;
        bit          injected = 1'b0;
        logic [31:0] wdata;
        budget       = v.nv * (v.lat + 2) + 20;
        wdata        = $urandom;
        core_rd_addr = v.rd;
        core_wr_addr = v.wr;
        core_wr_ena  = 1'b1;
        core_wr_data = wdata;
        core_lat     = v.lat;
        num_vec      = CW'(v.nv);
        src_base     = v.src;
        dst_base     = v.dst;
        batch_start  = 1'b1;
        @(negedge clk);
        batch_start  = 1'b0;
        for (int cyc = 0; cyc < budget && !got_done; cyc++) begin
            chk("wr_data", mem_wr_data, wdata);
            chk("wr_ena_gate", 32'(mem_wr_ena), 32'(in_run));
            if (core_start) begin
                chk("vec_idx", 32'(vec_idx), starts);
                chk("rd_reloc", 32'(mem_rd_addr), 32'(ref_addr(v.src, starts, v.rd)));
                chk("wr_reloc", 32'(mem_wr_addr), 32'(ref_addr(v.dst, starts, v.wr)));
                if (starts == v.nv - 1) begin
                    chk("rd_last", 32'(mem_rd_addr), 32'(v.exp_rd_last));
                    chk("wr_last", 32'(mem_wr_addr), 32'(v.exp_wr_last));
                end
                starts++;
            end
            if (batch_busy) busy++;
            if (batch_done) begin
                got_done = 1'b1;
                chk("done_time", cyc, (v.nv == 0) ? 0 : t_cd + 2);
                chk("busy_at_done", 32'(batch_busy), 32'd0);
            end
            if (in_run && core_done) begin
                t_cd   = cyc;
                in_run = 1'b0;
            end
            if (core_start) in_run = 1'b1;
            if (v.inject && in_run && starts == 1 && !injected) begin
                batch_start = 1'b1;
                num_vec     = CW'(v.nv + 5);
                injected    = 1'b1;
            end
            @(negedge clk);
            batch_start = 1'b0;
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no batch_done expected one within %0d cycles", budget);
        end
        chk("starts", starts, v.nv);
        chk("busy_cycles", busy, v.nv * (v.lat + 2));
        chk("done_pulse_len", 32'(batch_done), 32'd0);
`ifdef SOFTMAX_SCHED_PERF_EN
        chk("perf", perf_cycles, busy);
        repeat (3) @(negedge clk);
        chk("perf_hold", perf_cycles, busy);
`else
        repeat (3) @(negedge clk);
`endif
        chk("idle_busy", 32'(batch_busy), 32'd0);
    endtask

    initial begin
        vec_t v;
        int   waited;

        //            nv   src      dst      rd      wr      lat inj exp_rd   exp_wr
        tbl[0] = '{   3, 16'h0000, 16'h0400, 10'h005, 10'h07F, 40, 0, 16'h0105, 16'h057F};
        tbl[1] = '{   0, 16'h0100, 16'h0200, 10'h005, 10'h005,  5, 0, 16'h0000, 16'h0000};
        tbl[2] = '{   2, 16'hFFC0, 16'h1000, 10'h050, 10'h000,  6, 0, 16'h0090, 16'h1080};
        tbl[3] = '{   2, 16'h0200, 16'h0300, 10'h3FF, 10'h001, 10, 1, 16'h067F, 16'h0381};
        tbl[4] = '{   1, 16'h1234, 16'hFFFF, 10'h000, 10'h001,  1, 0, 16'h1234, 16'h0000};
        tbl[5] = '{ 255, 16'h0000, 16'h8000, 10'h000, 10'h000,  1, 0, 16'h7F00, 16'hFF00};

        core_rd_addr = 10'h123;
        core_wr_ena  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(batch_busy), 32'd0);
        chk("rst_done", 32'(batch_done), 32'd0);
        chk("rst_start", 32'(core_start), 32'd0);
        chk("rst_vec_idx", 32'(vec_idx), 32'd0);
        chk("rst_wr_ena", 32'(mem_wr_ena), 32'd0);
        chk("rst_rd_addr", 32'(mem_rd_addr), 32'h0123);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_wr_ena", 32'(mem_wr_ena), 32'd0);

        // Wrap-around: vector-0 read address folds past 0xFFFF.
        chk("wrap_ref", 32'(ref_addr(16'hFFC0, 0, 10'h050)), 32'h0010);

        for (int i = 0; i < 6; i++) run_batch(tbl[i]);

        for (int i = 0; i < 6; i++) begin
            v.nv     = $urandom_range(0, 4);
            v.src    = GAW'($urandom);
            v.dst    = GAW'($urandom);
            v.rd     = AW'($urandom);
            v.wr     = AW'($urandom);
            v.lat    = $urandom_range(1, 8);
            v.inject = 1'($urandom_range(0, 1));
            v.exp_rd_last = (v.nv > 0) ? ref_addr(v.src, v.nv - 1, v.rd) : '0;
            v.exp_wr_last = (v.nv > 0) ? ref_addr(v.dst, v.nv - 1, v.wr) : '0;
            run_batch(v);
        end

        // Asynchronous reset while the second vector is running.
        core_lat     = 40;
        core_rd_addr = 10'h0AA;
        num_vec      = 8'd3;
        src_base     = 16'h0400;
        dst_base     = 16'h0800;
        batch_start  = 1'b1;
        @(negedge clk);
        batch_start  = 1'b0;
        waited       = 0;
        while (vec_idx != 8'd1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("reached_vec1", 32'(vec_idx), 32'd1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(batch_busy), 32'd0);
        chk("arst_vec_idx", 32'(vec_idx), 32'd0);
        chk("arst_start", 32'(core_start), 32'd0);
        chk("arst_wr_ena", 32'(mem_wr_ena), 32'd0);
        chk("arst_rd_addr", 32'(mem_rd_addr), 32'h00AA);
`ifdef SOFTMAX_SCHED_PERF_EN
        chk("arst_perf", perf_cycles, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen_done = 0;
            int seen_start = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (batch_done) seen_done++;
                if (core_start) seen_start++;
            end
            chk("post_rst_done", seen_done, 0);
            chk("post_rst_start", seen_start, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
